// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Screen geometry, pixel field widths and arbiter state type
//               shared by the pixel write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam int X_W = 8;
    localparam int Y_W = 7;
    localparam int C_W = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

endpackage : vga_pkg
`default_nettype wire

// File: rtl/pixel_write_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker; searches upward from
//               (last_owner+1) mod N_CLIENTS and returns a one-hot grant.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import vga_pkg::*;
#(
    parameter int N_CLIENTS = 2,
    parameter int IDX_W     = 1
) (
    input  logic [N_CLIENTS-1:0] req_i,
    input  logic [IDX_W-1:0]     last_owner_i,
    output logic [N_CLIENTS-1:0] grant_o,
    output logic [IDX_W-1:0]     idx_o
);

    int w_dist;
    int w_best_dist;
    int w_best_idx;

    // Distance 0 is the client just after last_owner; the owner itself is farthest.
    always_comb begin : p_pick
        w_dist      = 0;
        w_best_dist = N_CLIENTS;
        w_best_idx  = 0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            w_dist = (i - int'(last_owner_i) - 1 + 2 * N_CLIENTS) % N_CLIENTS;
            if (req_i[i] && (w_dist < w_best_dist)) begin
                w_best_dist = w_dist;
                w_best_idx  = i;
            end
        end
        grant_o = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            grant_o[i] = (req_i != '0) && (i == w_best_idx);
        end
        idx_o = IDX_W'(w_best_idx);
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/pixel_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pixel_write_arbiter
// Description : Merges per-engine pixel streams into one registered VGA write
//               port, granting whole shapes round-robin and dropping
//               off-screen pixels.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_write_arbiter
    import vga_pkg::*;
#(
    parameter int N_CLIENTS = 2,
    parameter int SCREEN_W  = vga_pkg::SCREEN_W,
    parameter int SCREEN_H  = vga_pkg::SCREEN_H
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic [N_CLIENTS-1:0]       req_valid,
    input  logic [N_CLIENTS-1:0]       req_last,
    input  logic [X_W*N_CLIENTS-1:0]   req_x,
    input  logic [Y_W*N_CLIENTS-1:0]   req_y,
    input  logic [C_W*N_CLIENTS-1:0]   req_colour,
    output logic [N_CLIENTS-1:0]       req_ready,
    output logic [X_W-1:0]             x,
    output logic [Y_W-1:0]             y,
    output logic [C_W-1:0]             colour,
    output logic                       writeEn,
    output logic [N_CLIENTS-1:0]       grant,
    output logic [7:0]                 drop_count
);

    localparam int         c_IDX_W    = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam logic [7:0] c_DROP_MAX = 8'hFF;

    arb_state_e           state_q, state_d;
    logic [N_CLIENTS-1:0] grant_q, grant_d;
    logic [c_IDX_W-1:0]   owner_q, owner_d;
    logic [c_IDX_W-1:0]   last_owner_q, last_owner_d;

    logic [X_W-1:0]       x_q, x_d;
    logic [Y_W-1:0]       y_q, y_d;
    logic [C_W-1:0]       colour_q, colour_d;
    logic                 writeEn_q, writeEn_d;
    logic [7:0]           drop_q, drop_d;

    logic [N_CLIENTS-1:0] w_pick_grant;
    logic [c_IDX_W-1:0]   w_pick_idx;
    logic [X_W-1:0]       w_sel_x;
    logic [Y_W-1:0]       w_sel_y;
    logic [C_W-1:0]       w_sel_colour;
    logic                 w_sel_last;
    logic                 w_accept;
    logic                 w_on_screen;

    rr_pick #(
        .N_CLIENTS (N_CLIENTS),
        .IDX_W     (c_IDX_W)
    ) u_rr_pick (
        .req_i        (req_valid),
        .last_owner_i (last_owner_q),
        .grant_o      (w_pick_grant),
        .idx_o        (w_pick_idx)
    );

    // Input mux follows the one-hot grant; nothing is selected in IDLE.
    always_comb begin : p_mux
        w_sel_x      = '0;
        w_sel_y      = '0;
        w_sel_colour = '0;
        w_sel_last   = 1'b0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (grant_q[i]) begin
                w_sel_x      = req_x[i*X_W +: X_W];
                w_sel_y      = req_y[i*Y_W +: Y_W];
                w_sel_colour = req_colour[i*C_W +: C_W];
                w_sel_last   = req_last[i];
            end
        end
    end

    assign req_ready   = (state_q == BURST) ? (grant_q & req_valid) : '0;
    assign w_accept    = |req_ready;
    assign w_on_screen = (int'(w_sel_x) < SCREEN_W) && (int'(w_sel_y) < SCREEN_H);

    always_comb begin : p_fsm_next
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    state_d = BURST;
                    grant_d = w_pick_grant;
                    owner_d = w_pick_idx;
                end
            end
            BURST: begin
                if (w_accept && w_sel_last) begin
                    state_d      = IDLE;
                    grant_d      = '0;
                    last_owner_d = owner_q;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Off-screen accepts leave the write port untouched and only bump the counter.
    always_comb begin : p_write_next
        x_d       = x_q;
        y_d       = y_q;
        colour_d  = colour_q;
        writeEn_d = 1'b0;
        drop_d    = drop_q;
        if (w_accept) begin
            if (w_on_screen) begin
                x_d       = w_sel_x;
                y_d       = w_sel_y;
                colour_d  = w_sel_colour;
                writeEn_d = 1'b1;
            end else if (drop_q != c_DROP_MAX) begin
                drop_d = drop_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin : p_regs
        if (!resetn) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            owner_q      <= '0;
            last_owner_q <= c_IDX_W'(N_CLIENTS - 1);
            x_q          <= '0;
            y_q          <= '0;
            colour_q     <= '0;
            writeEn_q    <= 1'b0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            x_q          <= x_d;
            y_q          <= y_d;
            colour_q     <= colour_d;
            writeEn_q    <= writeEn_d;
            drop_q       <= drop_d;
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign colour     = colour_q;
    assign writeEn    = writeEn_q;
    assign grant      = grant_q;
    assign drop_count = drop_q;

endmodule : pixel_write_arbiter
`default_nettype wire

// File: tb/tb_pixel_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_write_arbiter
// Description : Self-checking bench: vector table, shape-level sequences and
//               random traffic against a behavioural arbiter model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_write_arbiter;

    localparam int N = 3;

    logic           clock = 1'b0;
    logic           resetn = 1'b0;
    logic [N-1:0]   req_valid, req_last, req_ready, grant;
    logic [8*N-1:0] req_x;
    logic [7*N-1:0] req_y;
    logic [3*N-1:0] req_colour;
    logic [7:0]     x;
    logic [6:0]     y;
    logic [2:0]     colour;
    logic           writeEn;
    logic [7:0]     drop_count;

    always #5 clock = ~clock;

    pixel_write_arbiter #(.N_CLIENTS(N), .SCREEN_W(160), .SCREEN_H(120)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_colour (req_colour),
        .req_ready  (req_ready),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .writeEn    (writeEn),
        .grant      (grant),
        .drop_count (drop_count)
    );

    // Per-client stimulus
    logic [N-1:0] v, l;
    logic [7:0]   px[N];
    logic [6:0]   py[N];
    logic [2:0]   pc[N];

    int           n_vec = 0;
    int           n_err = 0;
    int           cyc   = 0;
    logic [N-1:0] obs_ready;

    // Reference model: owner is a client number, -1 while no shape is open
    int           m_owner, m_last, m_drop;
    logic [7:0]   m_x;
    logic [6:0]   m_y;
    logic [2:0]   m_c;
    logic         m_we;

    function automatic logic bitof(input logic [N-1:0] vec, input int c);
        logic [N-1:0] s;
        if (c < 0) return 1'b0;
        s = vec >> c;
        return s[0];
    endfunction

    function automatic logic [N-1:0] onehot(input int c);
        if (c < 0) return '0;
        return N'(1) << c;
    endfunction

    function automatic int rr_next(input logic [N-1:0] req, input int last);
        for (int k = 1; k <= N; k++) begin
            if (bitof(req, (last + k) % N)) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_x[i*8 +: 8]      = px[i];
            req_y[i*7 +: 7]      = py[i];
            req_colour[i*3 +: 3] = pc[i];
        end
        req_valid = v;
        req_last  = l;
    endtask

    task automatic model_reset();
        m_owner = -1; m_last = N - 1; m_drop = 0;
        m_x = '0; m_y = '0; m_c = '0; m_we = 1'b0;
    endtask

    // One clock: drive, check ready mid-cycle, advance model, check registered outputs.
    task automatic tick();
        int acc;
        drive();
        #2;
        acc = -1;
        if (m_owner >= 0 && bitof(v, m_owner)) acc = m_owner;
        chk("req_ready", req_ready, onehot(acc));
        obs_ready = req_ready;
        m_we = 1'b0;
        if (acc >= 0) begin
            if (px[acc] < 160 && py[acc] < 120) begin
                m_x = px[acc]; m_y = py[acc]; m_c = pc[acc]; m_we = 1'b1;
            end else if (m_drop < 255) begin
                m_drop++;
            end
        end
        if (m_owner < 0) m_owner = rr_next(v, m_last);
        else if (acc >= 0 && bitof(l, acc)) begin
            m_last = m_owner; m_owner = -1;
        end
        @(posedge clock); #1; cyc++;
        chk("outputs", {x, y, colour, writeEn, grant, drop_count},
            {m_x, m_y, m_c, m_we, onehot(m_owner), 8'(m_drop)});
    endtask

    task automatic set_all(input logic [7:0] xx, input logic [6:0] yy, input logic [2:0] cc);
        for (int i = 0; i < N; i++) begin px[i] = xx; py[i] = yy; pc[i] = cc; end
    endtask

    task automatic do_reset();
        v = '0; l = '0; set_all(0, 0, 0); drive();
        resetn = 1'b0;
        repeat (2) @(posedge clock);
        #1; resetn = 1'b1;
        model_reset();
        chk("reset_state", {x, y, colour, writeEn, grant, drop_count, req_ready}, '0);
    endtask

    typedef struct {
        logic [N-1:0] v, l;
        logic [7:0] px; logic [6:0] py; logic [2:0] pc;
        logic [N-1:0] ready, grant;
        logic we; logic [7:0] ox; logic [6:0] oy; logic [2:0] oc; logic [7:0] drop;
    } vec_t;

    task automatic run_table();
        vec_t tbl[9];
        tbl[0] = '{3'b010, 3'b010,  10,  20, 5, 3'b000, 3'b010, 0,  0,   0, 0, 0};
        tbl[1] = '{3'b010, 3'b010,  10,  20, 5, 3'b010, 3'b000, 1, 10,  20, 5, 0};
        tbl[2] = '{3'b101, 3'b000, 200,   5, 1, 3'b000, 3'b100, 0, 10,  20, 5, 0};
        tbl[3] = '{3'b101, 3'b000, 159, 119, 0, 3'b100, 3'b100, 1, 159, 119, 0, 0};
        tbl[4] = '{3'b001, 3'b000, 160,   0, 7, 3'b000, 3'b100, 0, 159, 119, 0, 0};
        tbl[5] = '{3'b101, 3'b100, 160,   0, 7, 3'b100, 3'b000, 0, 159, 119, 0, 1};
        tbl[6] = '{3'b001, 3'b001,   0, 120, 3, 3'b000, 3'b001, 0, 159, 119, 0, 1};
        tbl[7] = '{3'b001, 3'b001,   0, 120, 3, 3'b001, 3'b000, 0, 159, 119, 0, 2};
        tbl[8] = '{3'b000, 3'b000,   0,   0, 0, 3'b000, 3'b000, 0, 159, 119, 0, 2};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            v = tbl[i].v; l = tbl[i].l; set_all(tbl[i].px, tbl[i].py, tbl[i].pc);
            tick();
            chk("tbl_ready", obs_ready, tbl[i].ready);
            chk("tbl_out", {grant, writeEn, x, y, colour, drop_count},
                {tbl[i].grant, tbl[i].we, tbl[i].ox, tbl[i].oy, tbl[i].oc, tbl[i].drop});
        end
    endtask

    task automatic run_stair();
        int k, writes, bad;
        do_reset();
        k = 0; writes = 0; bad = 0;
        for (int t = 0; t < 400 && k < 200; t++) begin
            v = 3'b001;
            px[0] = 8'(60 + k % 40); py[0] = 7'(40 + k / 40); pc[0] = 3'(k);
            l = (k == 199) ? 3'b001 : 3'b000;
            tick();
            if (obs_ready[0]) k++;
            if (writeEn) begin
                writes++;
                if (x < 60 || x > 99 || y < 40 || y > 44) bad++;
            end
        end
        v = '0; l = '0;
        tick();
        if (writeEn) writes++;
        chk("stair_accepts", k, 200);
        chk("stair_writes", writes, 200);
        chk("stair_range", bad, 0);
        chk("stair_drops", drop_count, 0);
    endtask

    task automatic run_simultaneous();
        int k0, t_last, t1, first, tc;
        do_reset();
        v = 3'b011; l = '0; set_all(1, 1, 1);
        k0 = 0; t_last = -100; t1 = -1; first = -1;
        for (int t = 0; t < 40 && t1 < 0; t++) begin
            l[0] = (k0 == 2);
            tc = cyc;
            tick();
            if (first < 0 && obs_ready != '0) first = obs_ready[0] ? 0 : 1;
            if (obs_ready[0]) begin
                k0++;
                if (k0 == 3) begin t_last = tc; v[0] = 1'b0; end
            end
            if (obs_ready[1]) t1 = tc;
        end
        chk("sim_first_client", first, 0);
        chk("sim_turnaround", t1 - t_last, 2);
    endtask

    task automatic run_hold();
        int k1, leak;
        do_reset();
        v = 3'b010; l = '0; set_all(50, 50, 2);
        k1 = 0; leak = 0;
        for (int t = 0; t < 10 && k1 < 3; t++) begin
            tick();
            if (obs_ready[1]) k1++;
        end
        v = 3'b001;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (obs_ready[0]) leak++;
        end
        chk("hold_grant_kept", grant, 3'b010);
        v = 3'b011; l = 3'b010;
        for (int t = 0; t < 5; t++) begin
            tick();
            if (obs_ready[0]) leak++;
            if (obs_ready[1]) break;
        end
        chk("hold_no_steal", leak, 0);
        v = 3'b001; l = '0;
        tick(); tick();
        chk("hold_next_owner", grant, 3'b001);
    endtask

    task automatic run_offscreen();
        logic [7:0] xs[4];
        logic [6:0] ys[4];
        int k, writes;
        xs = '{5, 170, 10, 20};
        ys = '{5, 10, 125, 20};
        do_reset();
        k = 0; writes = 0;
        for (int t = 0; t < 20 && k < 4; t++) begin
            v = 3'b001; px[0] = xs[k]; py[0] = ys[k]; pc[0] = 3'd4;
            l = (k == 3) ? 3'b001 : 3'b000;
            tick();
            if (obs_ready[0]) k++;
            if (writeEn) writes++;
        end
        chk("off_drops", drop_count, 2);
        chk("off_writes", writes, 2);
        k = 0; writes = 0;
        for (int t = 0; t < 700 && k < 300; t++) begin
            v = 3'b001; px[0] = 8'd200; py[0] = 7'd3;
            l = (k == 299) ? 3'b001 : 3'b000;
            tick();
            if (obs_ready[0]) k++;
            if (writeEn) writes++;
        end
        chk("sat_drops", drop_count, 255);
        chk("sat_writes", writes, 0);
    endtask

    task automatic run_async_reset();
        do_reset();
        v = 3'b001; l = '0; set_all(33, 44, 6);
        repeat (3) tick();
        px[0] = 8'd180;
        tick();
        px[0] = 8'd33;
        tick();
        drive();
        #2; resetn = 1'b0;
        #1;
        chk("async_reset", {x, y, colour, writeEn, grant, drop_count, req_ready}, '0);
        v = '0; l = '0; drive();
        @(posedge clock); #1; resetn = 1'b1;
        model_reset();
        v = 3'b111; l = 3'b111;
        tick();
        chk("post_reset_grant", grant, 3'b001);
        v = '0; l = '0;
        tick();
    endtask

    task automatic run_single_pixels();
        int t0, n, tc;
        int acc_q[$];
        int wr_q[$];
        do_reset();
        v = 3'b010; l = 3'b010; set_all(7, 8, 1);
        t0 = cyc; n = 0;
        for (int t = 0; t < 12; t++) begin
            tc = cyc;
            if (n == 3) v = '0;
            tick();
            if (obs_ready[1]) begin acc_q.push_back(tc - t0); n++; end
            if (writeEn) wr_q.push_back(tc + 1 - t0);
        end
        chk("sp_accepts", acc_q.size(), 3);
        chk("sp_writes", wr_q.size(), 3);
        for (int i = 0; i < 3 && i < acc_q.size(); i++) chk("sp_accept_cycle", acc_q[i], 2 * i + 1);
        for (int i = 0; i < 3 && i < wr_q.size(); i++)  chk("sp_write_cycle", wr_q[i], 2 * i + 2);
    endtask

    task automatic run_random();
        do_reset();
        for (int t = 0; t < 2500; t++) begin
            for (int i = 0; i < N; i++) begin
                v[i]  = ($urandom_range(0, 9) < 7);
                l[i]  = ($urandom_range(0, 4) == 0);
                px[i] = 8'($urandom_range(0, 175));
                py[i] = 7'($urandom_range(0, 127));
                pc[i] = 3'($urandom_range(0, 7));
            end
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        v = '0; l = '0; set_all(0, 0, 0); drive();
        model_reset();
        run_table();
        run_stair();
        run_simultaneous();
        run_hold();
        run_offscreen();
        run_async_reset();
        run_single_pixels();
        run_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_pixel_write_arbiter
`default_nettype wire

// File: doc/pixel_write_arbiter.md
# pixel_write_arbiter

Merges pixel write streams from several drawing engines (stair drawer, player sprite, score overlay) into the single x/y/colour/writeEn port of the VGA adapter. Each engine presents one pixel per cycle under a valid/ready handshake and marks the final pixel of a shape with `last`. The arbiter grants whole shapes atomically in round-robin order. It discards off-screen pixels and drives a registered write port one cycle after acceptance.

## Interface
Parameters:
- `N_CLIENTS`, 2: number of drawing engines (2..4).
- `SCREEN_W`, 160: visible columns; pixels with x ≥ SCREEN_W are dropped.
- `SCREEN_H`, 120: visible rows; pixels with y ≥ SCREEN_H are dropped.

Ports:
- `clock`  in  1: single clock for all logic.
- `resetn`  in  1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `req_valid`  in  N_CLIENTS: client i holds a pixel.
- `req_last`  in  N_CLIENTS: client i's current pixel ends its shape.
- `req_x`  in  8·N_CLIENTS: packed x, client i at bits [8i+7:8i].
- `req_y`  in  7·N_CLIENTS: packed y, client i at bits [7i+6:7i].
- `req_colour`  in  3·N_CLIENTS: packed colour, client i at bits [3i+2:3i].
- `req_ready`  out  N_CLIENTS: pixel of client i is accepted this cycle.
- `x`  out  8: registered pixel x to the VGA adapter.
- `y`  out  7: registered pixel y.
- `colour`  out  3: registered pixel colour.
- `writeEn`  out  1: registered write strobe.
- `grant`  out  N_CLIENTS: one-hot owner of the current shape; all zero in IDLE.
- `drop_count`  out  8: saturating count of dropped off-screen pixels.

## Operation
- States: IDLE and BURST.
- IDLE, with any `req_valid` set:
  - Pick a client by round-robin, searching upward from (last_owner+1) mod N_CLIENTS.
  - Load the one-hot `grant` and go to BURST.
  - No pixel is accepted in IDLE.
- BURST:
  - `req_ready[i] = grant[i] & req_valid[i]`, combinational. All other ready bits are 0.
  - An accept is `req_valid & req_ready` on the granted client.
  - An accept with `req_last=1` sets last_owner to that client, clears `grant` and returns to IDLE.
- Atomic shapes: a shape is never interrupted. The granted client may deassert valid for any number of cycles and keeps the grant. There is no timeout.
- Accepted pixel handling:
  - On-screen (x < SCREEN_W and y < SCREEN_H): register x/y/colour next cycle with `writeEn=1`.
  - Off-screen: keep `writeEn=0`, leave x/y/colour unchanged, and increment `drop_count`. The count saturates at 255.
  - Cycles with no accept: `writeEn=0`, x/y/colour hold their values.
- Downstream never stalls; the VGA adapter takes one write per cycle.
- Reset values: `x=0`, `y=0`, `colour=0`, `writeEn=0`, `grant=0`, `drop_count=0`, state IDLE, last_owner = N_CLIENTS−1 (so client 0 wins first).
- Reset asserted mid-burst aborts the shape immediately. Clients must restart their shapes after reset.

## Timing
- Grant latency: `req_valid` high in IDLE at cycle t gives `grant` at t+1 and the first `req_ready` at t+1.
- Write latency: a pixel accepted at cycle t appears on x/y/colour/writeEn at t+1.
- Throughput: one pixel per cycle within a shape.
- Turnaround: one idle cycle between shapes, covering the accept of `last` through the next grant.
  - Example: last accepted at t, IDLE at t+1, new grant at t+2.
- Single-pixel shape (valid and last together): 1 accept, 2 cycles of arbiter occupancy.
- Simultaneous requests in IDLE: strict round-robin. A client waiting behind a shape is granted within N_CLIENTS shapes.
- Colour 3'b000 is written like any other colour; erase passes are ordinary shapes.

## Structure
- Shared package `vga_pkg`, holding:
  - SCREEN_W and SCREEN_H constants.
  - Coordinate widths X_W=8, Y_W=7 and colour width C_W=3.
  - The arbiter state enum {IDLE, BURST}.
- Sub-module `rr_pick`: combinational round-robin picker. It takes a request vector and last_owner and returns a one-hot grant.
- Top level holds the FSM, the input mux, the range check, the output register and the drop counter.

## Test plan
- Single client draws a 40×5 stair at (60,40), `last` on pixel 200 → 200 writes, x 60..99, y 40..44, `writeEn` exactly 200 cycles, `drop_count=0`.
- Clients 0 and 1 assert valid in the same IDLE cycle right after reset → client 0 first; client 1 granted 2 cycles after client 0's `last`.
- Client 1 deasserts valid for 10 cycles mid-shape while client 0 requests → client 0's `req_ready` stays 0 until client 1's `last` is accepted.
- Shape containing x=170 and y=125 pixels → those pixels are accepted but not written, `drop_count` increases by 2, 300 off-screen pixels saturate it at 255.
- `resetn` pulsed low mid-burst → all outputs 0 asynchronously, state IDLE, next grant goes to client 0.
- Three single-pixel shapes from one client → accepts at cycles t+1, t+3, t+5 after valid at t; writes one cycle after each accept.
